// File: rtl/mul12_seq.sv
// Sequential 12x12 unsigned shift-and-add multiplier built around one shared
// 12-bit ripple adder; start/busy/done handshake with a held 24-bit product.

module adder12bits (
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic        cin,
    output logic [11:0] s,
    output logic        cout
);
    logic [12:0] c;

    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < 12; i++) begin : g_fa
            assign s[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    endgenerate

    assign cout = c[12];
endmodule

module mul12_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic        busy,
    output logic        done,
    output logic [23:0] p
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [11:0] m;
    logic [11:0] hi;
    logic [11:0] lo;
    logic [3:0]  cnt;

    logic        load;
    logic        step;

    logic [11:0] add_s;
    logic        add_c;
    logic        sel_c;
    logic [11:0] sel_s;
    logic [11:0] hi_sh;
    logic [11:0] lo_sh;

    adder12bits u_add (
        .a    (hi),
        .b    (m),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_c)
    );

    // Add the multiplicand only when the current multiplier bit is set, then
    // shift the 25-bit {carry, hi, lo} right by one; the carry lands in hi[11].
    always_comb begin
        if (lo[0]) begin
            sel_c = add_c;
            sel_s = add_s;
        end else begin
            sel_c = 1'b0;
            sel_s = hi;
        end
        hi_sh = {sel_c, sel_s[11:1]};
        lo_sh = {sel_s[0], lo[11:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == 4'd11) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m   <= 12'd0;
            hi  <= 12'd0;
            lo  <= 12'd0;
            cnt <= 4'd0;
            p   <= 24'd0;
        end else if (load) begin
            m   <= a;
            lo  <= b;
            hi  <= 12'd0;
            cnt <= 4'd0;
        end else if (step) begin
            hi  <= hi_sh;
            lo  <= lo_sh;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd11) begin
                p <= {hi_sh, lo_sh};
            end
        end
    end
endmodule

// File: tb/tb_mul12_seq.sv
// Scoreboard bench for mul12_seq: stimulus pushes expected products, a monitor
// pops and compares them on every done pulse.

module tb_mul12_seq;
    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] a;
    logic [11:0] b;
    logic        busy;
    logic        done;
    logic [23:0] p;

    int          total;
    int          bad;
    int          n_push;
    int          n_done;
    logic [23:0] exp_q[$];

    mul12_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding product.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", p, 24'hxxxxxx);
            end else begin
                chk("p_on_done", p, exp_q.pop_front());
            end
        end
    end

    task automatic push_exp(input logic [23:0] e);
        exp_q.push_back(e);
        n_push++;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of cycle 14.
    task automatic op(input logic [11:0] ta, input logic [11:0] tb_,
                      input logic [23:0] e, input logic [15:0] noise);
        logic bsy_ok;
        logic don_ok;
        bsy_ok = 1'b1;
        don_ok = 1'b1;
        a      = ta;
        b      = tb_;
        start  = 1'b1;
        push_exp(e);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (busy !== ((c <= 12) ? 1'b1 : 1'b0)) bsy_ok = 1'b0;
            if (done !== ((c == 13) ? 1'b1 : 1'b0)) don_ok = 1'b0;
            if (noise[c]) begin
                start = 1'b1;
                a     = 12'hFFF;
                b     = 12'hFFF;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("busy_window", {23'd0, bsy_ok}, 24'd1);
        chk("done_cycle13", {23'd0, don_ok}, 24'd1);
    endtask

    initial begin
        logic        ok;
        logic [11:0] ra;
        logic [11:0] rb;
        total  = 0;
        bad    = 0;
        n_push = 0;
        n_done = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = 12'd0;
        b      = 12'd0;

        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", {23'd0, busy}, 24'd0);
        chk("reset_done", {23'd0, done}, 24'd0);
        chk("reset_p", p, 24'h000000);
        rst = 1'b0;

        op(12'h123, 12'h456, 24'h04EDC2, 16'h0000);
        chk("p_hold_after_done", p, 24'h04EDC2);

        op(12'hFFF, 12'hFFF, 24'hFFE001, 16'h0000);
        op(12'h000, 12'hABC, 24'h000000, 16'h0000);
        op(12'h001, 12'hFFF, 24'h000FFF, 16'h0000);
        op(12'h800, 12'h002, 24'h001000, 16'h0000);

        // Starts in cycle 5 (RUN) and cycle 13 (DONE) must be ignored.
        op(12'h00F, 12'h00F, 24'h0000E1, 16'h2020);
        chk("busy_after_ignored", {23'd0, busy}, 24'd0);
        ok = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || p !== 24'h0000E1) ok = 1'b0;
        end
        chk("no_second_op", {23'd0, ok}, 24'd1);

        // Reset in cycle 6 of a run discards the product.
        a     = 12'hFFF;
        b     = 12'hFFF;
        start = 1'b1;
        ok    = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c <= 6 && busy !== 1'b1) ok = 1'b0;
            if (c >= 7 && (busy !== 1'b0 || p !== 24'h000000)) ok = 1'b0;
            if (done !== 1'b0) ok = 1'b0;
            rst = (c == 6);
        end
        chk("reset_mid_run", {23'd0, ok}, 24'd1);
        op(12'h123, 12'h456, 24'h04EDC2, 16'h0000);

        // Reset and start together: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        a     = 12'h055;
        b     = 12'h0AA;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_beats_start_busy", {23'd0, busy}, 24'd0);
        chk("rst_beats_start_p", p, 24'h000000);

        // Back-to-back with start held high.
        a     = 12'h010;
        b     = 12'h010;
        start = 1'b1;
        push_exp(24'h000100);
        ok = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            if (busy !== (((c >= 1 && c <= 12) || (c >= 15 && c <= 26)) ? 1'b1 : 1'b0)) ok = 1'b0;
            if (done !== ((c == 13 || c == 27) ? 1'b1 : 1'b0)) ok = 1'b0;
            if (c >= 14 && c <= 26 && p !== 24'h000100) ok = 1'b0;
            if (c == 1) begin
                a = 12'h003;
                b = 12'h005;
            end
            if (c == 14) push_exp(24'h00000F);
            if (c == 15) start = 1'b0;
        end
        chk("back_to_back", {23'd0, ok}, 24'd1);
        chk("p_after_b2b", p, 24'h00000F);

        for (int i = 0; i < 500; i++) begin
            ra = 12'($urandom);
            rb = 12'($urandom);
            op(ra, rb, 24'(ra) * 24'(rb), 16'h0000);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 24'(exp_q.size()), 24'd0);
        chk("done_per_start", 24'(n_done), 24'(n_push));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul12_seq.md
# mul12_seq

Sequential 12x12 unsigned shift-and-add multiplier. It time-shares one instance of the team's combinational 12-bit ripple adder `adder12bits` over 12 iterations to produce a 24-bit product. It sits beside the adder in the ALU and is the only block that drives the adder's operands while a multiply is in progress. Hosts use a start/busy/done handshake; the result stays registered until the next product completes.

## Interface
- No parameters. Width is fixed at 12 by the shared adder.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a multiply. Sampled only in IDLE.
- `a`  in  12  multiplicand. Captured on the accepted start.
- `b`  in  12  multiplier. Captured on the accepted start.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse in DONE; `p` is valid from this cycle.
- `p`  out  24  registered product. Holds until the next DONE.

## Operation
- **Registers**
  - `m[11:0]`: multiplicand.
  - `hi[11:0]`: accumulator high half.
  - `lo[11:0]`: multiplier, shifting into the product low half.
  - `cnt[3:0]`: iteration counter.
  - `state`: IDLE / RUN / DONE.
  - `p[23:0]`: result register.
- **Adder hookup:** A=`hi`, B=`m`, Cin=0. Sum S and carry Cout are used only in RUN.
- **IDLE, start=1:** `m`<=a, `lo`<=b, `hi`<=0, `cnt`<=0, go to RUN.
- **IDLE, start=0:** hold all registers.
- **RUN, each cycle:**
  - If `lo[0]`: {c,s} = {Cout,S}. Otherwise {c,s} = {0,`hi`}.
  - `hi`<={c,s[11:1]}, `lo`<={s[0],`lo[11:1]`}, `cnt`<=`cnt`+1.
  - If `cnt`==11: `p`<={c,s[11:1],s[0],`lo[11:1]`} (the post-shift {hi,lo}), go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then unconditionally go to IDLE.
- **start outside IDLE:** ignored, including during DONE. No queuing. `a`/`b` changes after capture have no effect.
- **Width rules:** the product never overflows 24 bits, so there is no overflow flag. The adder carry is always absorbed into `hi[11]` by the shift.
- **Reset (any state, including mid-RUN):** state=IDLE, `busy`=0, `done`=0, `p`=0, `hi`=`lo`=`m`=0, `cnt`=0. The in-flight product is discarded and never signalled.
- **Reset and start high in the same cycle:** reset wins; start is not accepted.

## Timing
- **Reset values:** `busy`=0, `done`=0, `p`=24'h000000.
- **Cycle numbering** (start sampled high in IDLE during cycle 0):
  - Cycles 1–12: RUN with `cnt`=0..11, `busy`=1.
  - Cycle 13: DONE, `done`=1, `busy`=0, `p` valid.
  - Cycle 14: IDLE.
- **Latency:** start to done is 13 cycles.
- **Throughput:** with start held high, a new operation is accepted every 14 cycles (accepted in cycles 0, 14, 28, ...).
- **Output registers:** `busy` and `done` decode from registered state. `p` changes only on the edge that enters DONE, and on reset.
- **Adder timing:** the adder path is combinational within one cycle. Timing closure requires a 12-bit ripple path plus mux within the clock period.

## Test plan
- **Reset:** assert rst 2 cycles -> busy=0, done=0, p=0x000000. Start pulse with a=0x123, b=0x456 -> done high exactly at cycle 13, p=0x04EDC2, busy high in cycles 1–12 only.
- **Corner products:**
  - a=0xFFF, b=0xFFF -> p=0xFFE001.
  - a=0x000, b=0xABC -> p=0x000000.
  - a=0x001, b=0xFFF -> p=0x000FFF.
  - a=0x800, b=0x002 -> p=0x001000.
- **Start ignored mid-operation:** start a=0x00F, b=0x00F, then pulse start with a=0xFFF, b=0xFFF in cycles 5 and 13 -> p=0x0000E1, no second done, busy=0 in cycle 14.
- **Reset mid-operation:** start a=0xFFF, b=0xFFF, assert rst in cycle 6 -> busy=0 next cycle, no done pulse ever, p stays 0x000000. A fresh start then completes normally.
- **Back-to-back:** hold start=1 with a=0x010, b=0x010 then a=0x003, b=0x005 -> done pulses in cycles 13 and 27, p=0x000100 then 0x00000F, p stable between pulses.
- **Random:** 500 random a/b pairs checked against a 24-bit reference multiply -> p matches on every done, exactly one done per accepted start.
